// File: rtl/native_bus_arbiter.sv
// rtl/native_bus_arbiter.sv - round-robin arbiter sharing one native r_wn/addr/wdata/rdata bus
// Optional address-window check: define NATIVE_BUS_ARB_RANGE_CHECK_EN.
module native_bus_arbiter #(
    parameter int          NUM_REQ    = 2,
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 8,
    parameter int unsigned RANGE0_LO  = 0,
    parameter int unsigned RANGE0_HI  = 16,
    parameter int unsigned RANGE1_LO  = 32,
    parameter int unsigned RANGE1_HI  = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_r_wn,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          bus_r_wn,
    output logic [ADDR_WIDTH-1:0]         bus_addr,
    output logic [DATA_WIDTH-1:0]         bus_wdata,
    input  logic [DATA_WIDTH-1:0]         bus_rdata,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef NATIVE_BUS_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    r_wn_q, r_wn_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    oor_q, oor_d;

    logic                    found;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_r_wn;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [31:0]             sel_addr32;
    logic                    sel_in_range;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        sel_r_wn  = 1'b1;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_r_wn  = req_r_wn[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_addr32   = 32'(sel_addr);
    assign sel_in_range = ((sel_addr32 >= RANGE0_LO) && (sel_addr32 < RANGE0_HI)) ||
                          ((sel_addr32 >= RANGE1_LO) && (sel_addr32 < RANGE1_HI));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            idx_q   <= '0;
            r_wn_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            rdata_q <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            r_wn_q  <= r_wn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
            oor_q   <= oor_d;
        end
    end

    // addr_q/wdata_q double as the bus drivers, so they hold between transactions.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        r_wn_d  = r_wn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gnt_d   = gnt_q;
        rdata_d = rdata_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d          = sel_idx;
                    r_wn_d         = sel_r_wn;
                    addr_d         = sel_addr;
                    wdata_d        = sel_wdata;
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    oor_d          = RANGE_CHECK && !sel_in_range;
                    state_d        = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (oor_q) begin
                    rdata_d = '0;
                end else if (r_wn_q) begin
                    rdata_d = bus_rdata;
                end
                state_d = RESP;
            end
            RESP: begin
                ptr_d   = idx_q;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        done = '0;
        if (state_q == RESP) begin
            done[idx_q] = 1'b1;
        end
    end

`ifdef NATIVE_BUS_ARB_RANGE_CHECK_EN
    assign err = done & {NUM_REQ{oor_q}};
`else
    assign err = '0;
`endif

    assign gnt       = gnt_q;
    assign rsp_rdata = rdata_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_r_wn  = !((state_q == ACCESS) && !r_wn_q && !oor_q);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_native_bus_arbiter.sv
// tb/tb_native_bus_arbiter.sv - directed self-checking bench for native_bus_arbiter
module tb_native_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 8;

`ifdef NATIVE_BUS_ARB_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_r_wn;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic [DW-1:0]   rsp_rdata;
    logic            bus_r_wn;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [DW-1:0]   bus_rdata;
    logic            busy;

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_errors = 0;

    native_bus_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_r_wn(req_r_wn),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rsp_rdata(rsp_rdata), .bus_r_wn(bus_r_wn),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Bus device: combinational read, write on the strobe edge.
    assign bus_rdata = mem[bus_addr];
    always @(posedge clk) begin
        if (!rst && !bus_r_wn) mem[bus_addr] <= bus_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [7:0] a, input logic [7:0] d);
        req_r_wn[i]        = rw;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Full single-requester transaction checked cycle by cycle.
    task automatic run_txn(input string tag, input int i, input logic rw, input logic [7:0] a,
                           input logic [7:0] d, input logic exp_strobe, input logic exp_err,
                           input logic [7:0] exp_rdata);
        logic [N-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        set_req(i, rw, a, d);
        req[i] = 1'b1;
        tick();
        check({tag, "_setup_gnt"}, 32'(gnt), 32'(oh));
        check({tag, "_setup_addr"}, 32'(bus_addr), 32'(a));
        check({tag, "_setup_rwn"}, 32'(bus_r_wn), 32'd1);
        check({tag, "_setup_busy"}, 32'(busy), 32'd1);
        if (!rw) check({tag, "_setup_wdata"}, 32'(bus_wdata), 32'(d));
        set_req(i, ~rw, 8'hFF, 8'hFF);
        tick();
        check({tag, "_access_rwn"}, 32'(bus_r_wn), exp_strobe ? 32'd0 : 32'd1);
        check({tag, "_access_addr"}, 32'(bus_addr), 32'(a));
        check({tag, "_access_done"}, 32'(done), 32'd0);
        tick();
        check({tag, "_resp_done"}, 32'(done), 32'(oh));
        check({tag, "_resp_err"}, 32'(err), exp_err ? 32'(oh) : 32'd0);
        check({tag, "_resp_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        check({tag, "_resp_rwn"}, 32'(bus_r_wn), 32'd1);
        req[i] = 1'b0;
        tick();
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    int done_cnt [N];

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        mem[7]  = 8'h11;
        mem[20] = 8'h77;
        req = '0;
        req_r_wn = '1;
        req_addr = '0;
        req_wdata = '0;
        rst = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rwn", 32'(bus_r_wn), 32'd1);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_wdata", 32'(bus_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        run_txn("wr5", 0, 1'b0, 8'd5, 8'd6, 1'b1, 1'b0, 8'h00);
        check("wr5_mem", 32'(mem[5]), 32'd6);
        run_txn("rd5", 0, 1'b1, 8'd5, 8'h00, 1'b0, 1'b0, 8'h06);

        // Contention from reset: requester 0 first, then strict alternation.
        do_reset();
        set_req(0, 1'b1, 8'd1, 8'h00);
        set_req(1, 1'b1, 8'd2, 8'h00);
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        req = 2'b11;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k % 4 == 0) check($sformatf("cont_gnt%0d", k / 4), 32'(gnt), (k % 8 == 0) ? 32'd1 : 32'd2);
            if (gnt == 2'b11) check("cont_gnt_overlap", 32'(gnt), 32'd1);
            for (int r = 0; r < N; r++) if (done[r]) done_cnt[r]++;
        end
        req = '0;
        check("cont_busy_end", 32'(busy), 32'd0);
        check("cont_done0", 32'(done_cnt[0]), 32'd2);
        check("cont_done1", 32'(done_cnt[1]), 32'd2);

        // Late request: req[1] rises during requester 0's ACCESS.
        do_reset();
        set_req(0, 1'b0, 8'd10, 8'hAA);
        set_req(1, 1'b1, 8'd10, 8'h00);
        req[0] = 1'b1;
        tick();
        tick();
        req[1] = 1'b1;
        tick();
        check("late_resp_done", 32'(done), 32'd1);
        check("late_resp_gnt", 32'(gnt), 32'd1);
        req[0] = 1'b0;
        tick();
        check("late_idle_gnt", 32'(gnt), 32'd0);
        tick();
        check("late_setup_gnt", 32'(gnt), 32'd2);
        tick();
        tick();
        check("late_resp1_done", 32'(done), 32'd2);
        check("late_resp1_rdata", 32'(rsp_rdata), 32'hAA);
        req[1] = 1'b0;
        tick();

        // Reset in the middle of a write strobe.
        set_req(0, 1'b0, 8'd7, 8'h99);
        req[0] = 1'b1;
        tick();
        tick();
        check("rstmid_strobe", 32'(bus_r_wn), 32'd0);
        rst = 1'b1;
        #1;
        check("rstmid_rwn", 32'(bus_r_wn), 32'd1);
        check("rstmid_gnt", 32'(gnt), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        req = '0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rstmid_nodone", 32'(done), 32'd0);
        end
        check("rstmid_mem7", 32'(mem[7]), 32'h11);

        // Address windows: 20 lies outside both, 33 inside the second.
        run_txn("wr20", 0, 1'b0, 8'd20, 8'h5A, !RC, RC, 8'h00);
        check("wr20_mem", 32'(mem[20]), RC ? 32'h77 : 32'h5A);
        run_txn("rd20", 0, 1'b1, 8'd20, 8'h00, 1'b0, RC, RC ? 8'h00 : 8'h5A);
        run_txn("wr33", 0, 1'b0, 8'd33, 8'h3C, 1'b1, 1'b0, RC ? 8'h00 : 8'h5A);
        check("wr33_mem", 32'(mem[33]), 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
